// File: rtl/acondicionador_botones_pkg.sv
// Shared button indices, priority order and the one-at-a-time arbiter
// used by the button conditioner.
package botones_pkg;

   localparam int NUM_BTN = 4;
   localparam int BTN_AD  = 0;
   localparam int BTN_AT  = 1;
   localparam int BTN_SEL = 2;
   localparam int BTN_CLC = 3;

   // Highest priority first
   localparam int PRIO_ORDER [NUM_BTN] = '{BTN_CLC, BTN_SEL, BTN_AT, BTN_AD};

   // Drops rises that arrive while another button is already held (CLC is exempt),
   // then keeps only the highest-priority survivor.
   function automatic logic [NUM_BTN-1:0] arbitrar(input logic [NUM_BTN-1:0] raw,
                                                   input logic [NUM_BTN-1:0] lvl_prev);
      logic [NUM_BTN-1:0] ok;
      logic [NUM_BTN-1:0] others;
      logic [NUM_BTN-1:0] res;
      ok  = raw;
      res = '0;
      for (int i = 0; i < NUM_BTN; i++) begin
         others    = lvl_prev;
         others[i] = 1'b0;
         if (i != BTN_CLC && |others) ok[i] = 1'b0;
      end
      for (int p = 0; p < NUM_BTN; p++) begin
         if (res == '0 && ok[PRIO_ORDER[p]]) res[PRIO_ORDER[p]] = 1'b1;
      end
      return res;
   endfunction

endpackage

// File: rtl/acondicionador_botones_debounce_canal.sv
// One button channel: 2-flop synchroniser on the inverted pin, debounce counter,
// registered level, and combinational next-level / rise for the current edge.
module debounce_canal #(
   parameter int DEB_CYCLES = 160000,
   parameter int CNT_W      = 18
) (
   input  logic clk,
   input  logic reset,
   input  logic pin_n,
   output logic level,
   output logic nivel_sig,
   output logic rise
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

   logic             sync1;
   logic             s;
   logic [CNT_W-1:0] cnt;
   logic             done;

   // s has disagreed with level for DEB_CYCLES consecutive edges including this one
   assign done      = (s != level) && (cnt == CNT_MAX);
   assign nivel_sig = done ? s : level;
   assign rise      = done && s;

   always_ff @(posedge clk) begin
      if (!reset) begin
         sync1 <= 1'b0;
         s     <= 1'b0;
         level <= 1'b0;
         cnt   <= '0;
      end else begin
         sync1 <= ~pin_n;
         s     <= sync1;
         if (s == level) begin
            cnt <= '0;
         end else if (done) begin
            level <= s;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/acondicionador_botones.sv
// Conditions the four active-low menu buttons into debounced levels and one arbitrated
// press pulse per cycle. Optional hold-to-repeat on AD/AT with macro AUTO_REPEAT_EN.
module acondicionador_botones
   import botones_pkg::*;
#(
   parameter int DEB_CYCLES    = 160000,
   parameter int CNT_W         = 18,
   parameter int REPEAT_DELAY  = 8000000,
   parameter int REPEAT_PERIOD = 4000000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_BTN-1:0] btn_n,
   output logic [NUM_BTN-1:0] btn_level,
   output logic [NUM_BTN-1:0] btn_pulse,
   output logic               btn_busy
);

   if (DEB_CYCLES < 2 || (DEB_CYCLES >> CNT_W) != 0) begin : g_bad_deb_cfg
      $error("DEB_CYCLES must be >= 2 and fit in CNT_W bits");
   end
   if (REPEAT_PERIOD < 1 || REPEAT_DELAY < REPEAT_PERIOD) begin : g_bad_repeat_cfg
      $error("REPEAT_PERIOD must be >= 1 and not exceed REPEAT_DELAY");
   end

   logic [NUM_BTN-1:0] nivel_sig;
   logic [NUM_BTN-1:0] rise;
   logic [NUM_BTN-1:0] raw;

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_canal
      debounce_canal #(
         .DEB_CYCLES (DEB_CYCLES),
         .CNT_W      (CNT_W)
      ) u_canal (
         .clk       (clk),
         .reset     (reset),
         .pin_n     (btn_n[i]),
         .level     (btn_level[i]),
         .nivel_sig (nivel_sig[i]),
         .rise      (rise[i])
      );
   end

`ifdef AUTO_REPEAT_EN
   localparam int HOLD_W = $clog2(REPEAT_DELAY + 1);

   logic [HOLD_W-1:0] hold_cnt;
   logic              solo;
   logic              rep;

   // Only AD or AT alone may repeat; anything else pressed restarts the hold
   assign solo = (btn_level == (NUM_BTN'(1) << BTN_AD)) ||
                 (btn_level == (NUM_BTN'(1) << BTN_AT));
   assign rep  = solo && (hold_cnt == HOLD_W'(REPEAT_DELAY - 1));
   assign raw  = rise | (rep ? btn_level : '0);

   always_ff @(posedge clk) begin
      if (!reset || !solo) begin
         hold_cnt <= '0;
      end else if (rep) begin
         hold_cnt <= HOLD_W'(REPEAT_DELAY - REPEAT_PERIOD);
      end else begin
         hold_cnt <= hold_cnt + 1'b1;
      end
   end
`else
   assign raw = rise;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         btn_pulse <= '0;
         btn_busy  <= 1'b0;
      end else begin
         btn_pulse <= arbitrar(raw, btn_level);
         btn_busy  <= |nivel_sig;
      end
   end

endmodule

// File: tb/tb_acondicionador_botones.sv
// Randomised and directed bench for acondicionador_botones against a behavioural model.
module tb_acondicionador_botones;

   localparam int DEB = 4;
   localparam int RD  = 10;
   localparam int RP  = 5;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] btn_n = 4'hF;
   logic [3:0] btn_level;
   logic [3:0] btn_pulse;
   logic       btn_busy;

   always #5 clk = ~clk;

   acondicionador_botones #(
      .DEB_CYCLES    (DEB),
      .CNT_W         (3),
      .REPEAT_DELAY  (RD),
      .REPEAT_PERIOD (RP)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .btn_n     (btn_n),
      .btn_level (btn_level),
      .btn_pulse (btn_pulse),
      .btn_busy  (btn_busy)
   );

   int n_chk  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model: pin delayed two edges, level follows after DEB edges of disagreement
   logic [3:0] m_s1 = '0, m_s = '0, m_lvl = '0, m_pulse = '0;
   logic       m_busy = 1'b0;
   int         m_run [4] = '{0, 0, 0, 0};
   int         m_hold = 0;

   always @(posedge clk) begin : model_blk
      logic [3:0] new_lvl;
      logic [3:0] cand;
      logic [3:0] mask;
      if (!reset) begin
         m_s1 = '0; m_s = '0; m_lvl = '0; m_pulse = '0; m_busy = 1'b0; m_hold = 0;
         for (int i = 0; i < 4; i++) m_run[i] = 0;
      end else begin
         new_lvl = m_lvl;
         for (int i = 0; i < 4; i++) begin
            if (m_s[i] != m_lvl[i]) begin
               m_run[i]++;
               if (m_run[i] == DEB) begin
                  new_lvl[i] = m_s[i];
                  m_run[i]   = 0;
               end
            end else begin
               m_run[i] = 0;
            end
         end
         cand = new_lvl & ~m_lvl;
`ifdef AUTO_REPEAT_EN
         if (m_lvl == 4'b0001 || m_lvl == 4'b0010) begin
            m_hold++;
            if (m_hold >= RD && (m_hold - RD) % RP == 0) cand = cand | m_lvl;
         end else begin
            m_hold = 0;
         end
`endif
         for (int i = 0; i < 3; i++) begin
            mask = 4'b0001 << i;
            if ((m_lvl & ~mask) != 4'b0000) cand[i] = 1'b0;
         end
         if (cand[3])      m_pulse = 4'b1000;
         else if (cand[2]) m_pulse = 4'b0100;
         else if (cand[1]) m_pulse = 4'b0010;
         else if (cand[0]) m_pulse = 4'b0001;
         else              m_pulse = 4'b0000;
         m_busy = |new_lvl;
         m_lvl  = new_lvl;
         m_s    = m_s1;
         m_s1   = ~btn_n;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("model_level", btn_level, m_lvl);
         check("model_pulse", btn_pulse, m_pulse);
         check("model_busy", btn_busy, m_busy);
         check("pulse_onehot0", $onehot0(btn_pulse), 1);
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int rate;
      reset = 1'b0;
      btn_n = 4'hF;
      step(2);
      chk_en = 1'b1;
      check("reset_level", btn_level, 0);
      check("reset_pulse", btn_pulse, 0);
      check("reset_busy", btn_busy, 0);
      reset = 1'b1;
      step(4);
      check("idle_level", btn_level, 0);

      // Clean AD press: level and pulse together on the sixth edge
      btn_n = 4'b1110;
      step(5);
      check("ad_level_early", btn_level, 0);
      step(1);
      check("ad_pulse", btn_pulse, 4'b0001);
      check("ad_level", btn_level, 4'b0001);
      check("ad_busy", btn_busy, 1);
      step(1);
      check("ad_pulse_once", btn_pulse, 0);
      btn_n = 4'hF;
      step(10);

      // SEL bouncing every two cycles never settles
      for (int k = 0; k < 10; k++) begin
         btn_n[2] = ~btn_n[2];
         step(2);
      end
      step(8);
      check("bounce_level", btn_level, 0);

      // AT+SEL+CLC together: only CLC issues
      btn_n = 4'b0001;
      step(6);
      check("simul_pulse", btn_pulse, 4'b1000);
      check("simul_level", btn_level, 4'b1110);
      step(1);
      check("simul_pulse_once", btn_pulse, 0);
      btn_n = 4'hF;
      step(10);

      // Lockout: AD blocked by held SEL, CLC still passes
      btn_n = 4'b1011;
      step(8);
      btn_n = 4'b1010;
      step(6);
      check("lock_level", btn_level, 4'b0101);
      check("lock_ad_pulse", btn_pulse, 0);
      btn_n = 4'b0010;
      step(6);
      check("lock_clc_pulse", btn_pulse, 4'b1000);
      check("lock_clc_level", btn_level, 4'b1101);
      btn_n = 4'hF;
      step(10);

      // Reset during a hold, then a fresh press pulse
      btn_n = 4'b1110;
      step(8);
      reset = 1'b0;
      step(1);
      check("midrst_level", btn_level, 0);
      check("midrst_busy", btn_busy, 0);
      check("midrst_pulse", btn_pulse, 0);
      reset = 1'b1;
      step(5);
      check("midrst_level_early", btn_level, 0);
      step(1);
      check("midrst_repulse", btn_pulse, 4'b0001);
      btn_n = 4'hF;
      step(10);

`ifdef AUTO_REPEAT_EN
      btn_n = 4'b1101;
      step(6);
      check("rep_first", btn_pulse, 4'b0010);
      step(9);
      check("rep_gap", btn_pulse, 0);
      step(1);
      check("rep_delay", btn_pulse, 4'b0010);
      step(5);
      check("rep_period1", btn_pulse, 4'b0010);
      step(5);
      check("rep_period2", btn_pulse, 4'b0010);
      btn_n = 4'hF;
      step(10);
`endif

      // Random pin activity with varying bounce rate and occasional resets
      for (int blk = 0; blk < 8; blk++) begin
         rate = $urandom_range(2, 24);
         for (int c = 0; c < 400; c++) begin
            for (int b = 0; b < 4; b++) begin
               if ($urandom_range(0, rate - 1) == 0) btn_n[b] = ~btn_n[b];
            end
            reset = ($urandom_range(0, 299) != 0);
            step(1);
         end
      end
      reset = 1'b1;
      step(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
